datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
//  Responder side of the control-strobe interface: holds PC, SP, opcode, data register and tape RAM.
//  Executes each one-cycle strobe from the control FSM (fetch, writeback, ALU, PC update).
//  Drives the opcode and data values back to the controller and addresses program memory.
//  Program memory is external with asynchronous read.
// PARAMETERS
//  TAPE_AW    8       tape address width; tape = 2**TAPE_AW bytes, SP is TAPE_AW bits
//  PC_RESET   16'h0   PC value after reset
// PORTS
//  clock               in   1   sole clock, rising edge
//  reset_n             in   1   asynchronous active-low reset
//  opcode_fetch        in   1   opcode <= progmem_rdata
//  tape_fetch          in   1   data <= {8'h00, tape[sp]}
//  tape_writeback      in   1   tape[sp] <= data[7:0]
//  sp_fetch            in   1   data <= zero-extended sp
//  sp_writeback        in   1   sp <= data[TAPE_AW-1:0]
//  progmem_fetch_low   in   1   data[7:0] <= progmem_rdata
//  progmem_fetch_high  in   1   data[15:8] <= progmem_rdata
//  alu_en              in   1   data <= data +/- 1
//  alu_op              in   1   0 = increment, 1 = decrement; ignored unless alu_en
//  pc_inc              in   1   pc <= pc + 1
//  pc_writeback        in   1   pc <= pc + data (relative)
//  progmem_rdata       in   8   program byte at progmem_addr
//  progmem_addr        out  16  equals pc
//  opcode              out  8   latched opcode
//  data                out  16  data register
//  busy                out  1   high = strobes ignored
//  protocol_error      out  1   sticky: illegal strobe combination seen
// BEHAVIOUR
//  - Reset: pc=PC_RESET, sp=0, data=0, opcode=0, protocol_error=0; busy as described under CONFIGURATION.
//  - All updates take effect on the rising edge of the strobe cycle; the result is visible on outputs
//    the next cycle (1-cycle latency). Reads use pre-edge register values.
//  - Arithmetic: data +/- 1 is 16-bit and wraps (0-1 = 16'hFFFF).
//  - sp_writeback truncates to TAPE_AW bits, so SP wraps modulo 2**TAPE_AW.
//  - tape_writeback stores data[7:0] only.
//  - pc_writeback: pc <= pc + data, data read as signed 16-bit, mod 2**16. Uses pc before this edge.
//  - Data-register writers, priority high to low:
//    tape_fetch > sp_fetch > alu_en > progmem_fetch_low/high.
//    progmem_fetch_low and progmem_fetch_high together are legal; both bytes load.
//  - pc_inc with pc_writeback in the same cycle: pc_writeback wins (pc + data).
//  - Any two data-register writers in one cycle (excluding the low/high pair), or pc_inc with
//    pc_writeback, sets protocol_error = 1. It holds until reset_n.
//  - tape_writeback with tape_fetch in the same cycle: tape_fetch reads the old byte; the write
//    also completes. This is legal.
//  - opcode_fetch may coincide with any strobe. pc_inc with opcode_fetch or a progmem fetch is
//    legal; the fetch uses the old pc.
//  - Strobes arriving while busy=1 are dropped; no state changes and protocol_error is not set.
//  - reset_n asserted mid-operation: registers clear immediately. Tape contents are not cleared
//    unless DATAPATH_TAPE_CLEAR_EN is defined. An in-progress clear restarts from address 0.
// CONFIGURATION
//  DATAPATH_TAPE_CLEAR_EN defined:
//    - After reset_n deasserts, a clear counter writes 0 to tape[0..2**TAPE_AW-1], one byte
//      per cycle. busy = 1 throughout.
//    - busy falls on the cycle after the last address is written (2**TAPE_AW cycles).
//  Not defined:
//    - No clear; busy is constant 0. Tape contents are undefined after power-up.
// TESTING
//  1. Reset, progmem_rdata=8'h07, pulse opcode_fetch -> next cycle opcode=8'h07, progmem_addr=0.
//  2. 3x (tape_fetch; alu_en, alu_op=0; tape_writeback) at sp=0, then tape_fetch -> data=16'h0003.
//  3. tape[0]=0, tape_fetch; alu_en, alu_op=1 -> data=16'hFFFF; tape_writeback, tape_fetch -> data=16'h00FF.
//  4. sp=0: sp_fetch; alu_en, alu_op=1; sp_writeback -> sp=8'hFF; repeat with alu_op=0 -> sp=0.
//  5. pc=16'h0010: fetch_low with rdata=8'hFC; fetch_high with rdata=8'hFF; pc_writeback -> pc=16'h000C.
//     Then pc_inc with pc_writeback, data=2 -> pc=16'h000E, protocol_error=1, holds until reset.
//  6. Macro on, TAPE_AW=8: write tape[5]=8'h55, reset, busy high exactly 256 cycles, strobes dropped
//     meanwhile. After that, sp=5, tape_fetch -> data=0. Reset at cycle 100 restarts the clear.

Source files
------------

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module      : datapath
// Description : Responder side of the control-strobe interface. Holds the
//               program counter, the tape stack pointer, the latched opcode,
//               the 16-bit data register and the tape RAM. It executes each
//               one-cycle strobe issued by the control FSM. Every update lands
//               on the rising edge of the strobe cycle and is visible on the
//               outputs one cycle later. All reads use pre-edge values.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: DATAPATH_TAPE_CLEAR_EN
//   defined   : after reset_n releases, the tape is zero-filled one byte per
//               cycle (2**TAPE_AW cycles). busy is high for the whole fill.
//   undefined : no fill. busy is tied low and the tape powers up undefined.
// ----------------------------------------------------------------------------
// Parameters
//   TAPE_AW   tape address width (tape = 2**TAPE_AW bytes, SP width)
//   PC_RESET  program counter value after reset
// Ports
//   clock               in   1   sole clock, rising edge
//   reset_n             in   1   asynchronous active-low reset
//   opcode_fetch        in   1   opcode <= progmem_rdata
//   tape_fetch          in   1   data <= {8'h00, tape[sp]}
//   tape_writeback      in   1   tape[sp] <= data[7:0]
//   sp_fetch            in   1   data <= zero-extended sp
//   sp_writeback        in   1   sp <= data[TAPE_AW-1:0]
//   progmem_fetch_low   in   1   data[7:0]  <= progmem_rdata
//   progmem_fetch_high  in   1   data[15:8] <= progmem_rdata
//   alu_en              in   1   data <= data +/- 1
//   alu_op              in   1   0 = increment, 1 = decrement
//   pc_inc              in   1   pc <= pc + 1
//   pc_writeback        in   1   pc <= pc + signed(data)
//   progmem_rdata       in   8   program byte at progmem_addr
//   progmem_addr        out  16  current pc
//   opcode              out  8   latched opcode
//   data                out  16  data register
//   busy                out  1   strobes are ignored while high
//   protocol_error      out  1   sticky illegal-strobe-combination flag
// ============================================================================
module datapath #(
   parameter int          TAPE_AW  = 8,
   parameter logic [15:0] PC_RESET = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        opcode_fetch,
   input  logic        tape_fetch,
   input  logic        tape_writeback,
   input  logic        sp_fetch,
   input  logic        sp_writeback,
   input  logic        progmem_fetch_low,
   input  logic        progmem_fetch_high,
   input  logic        alu_en,
   input  logic        alu_op,
   input  logic        pc_inc,
   input  logic        pc_writeback,
   input  logic [7:0]  progmem_rdata,
   output logic [15:0] progmem_addr,
   output logic [7:0]  opcode,
   output logic [15:0] data,
   output logic        busy,
   output logic        protocol_error
);

   localparam int TAPE_DEPTH = 2 ** TAPE_AW;

   // ------------------------------------------------------------------------
   // Architectural registers
   // ------------------------------------------------------------------------
   logic [15:0]        pc_q,     pc_d;
   logic [TAPE_AW-1:0] sp_q,     sp_d;
   logic [15:0]        data_q,   data_d;
   logic [7:0]         opcode_q, opcode_d;
   logic               perr_q,   perr_d;

   // Tape RAM and its single write port
   logic [7:0]         tape_mem [TAPE_DEPTH];
   logic [7:0]         w_tape_rd;
   logic               w_tape_we;
   logic [TAPE_AW-1:0] w_tape_waddr;
   logic [7:0]         w_tape_wdata;

   logic               w_busy;
   logic               w_strobe_en;
   logic [2:0]         w_wr_cnt;
   logic [15:0]        w_sp_ext;

   // ------------------------------------------------------------------------
   // Optional power-up tape clear
   // ------------------------------------------------------------------------
`ifdef DATAPATH_TAPE_CLEAR_EN
   logic               clr_active_q;
   logic [TAPE_AW-1:0] clr_addr_q;

   // Reset (re)arms the fill from address 0, so a reset mid-fill restarts it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clr_active_q <= 1'b1;
         clr_addr_q   <= '0;
      end else if (clr_active_q) begin
         clr_addr_q <= clr_addr_q + TAPE_AW'(1);
         // Last address written this edge: busy drops on the next cycle.
         if (&clr_addr_q) begin
            clr_active_q <= 1'b0;
         end
      end
   end

   assign w_busy = clr_active_q;
`else
   assign w_busy = 1'b0;
`endif

   // Strobes only count when the block is idle; dropped strobes must not
   // touch any state, including the sticky error flag.
   assign w_strobe_en = ~w_busy;

   assign w_tape_rd = tape_mem[sp_q];
   assign w_sp_ext  = 16'(sp_q);

   // Number of distinct data-register writers this cycle. The low/high
   // program-memory byte loads form one writer.
   assign w_wr_cnt = 3'(tape_fetch) + 3'(sp_fetch) + 3'(alu_en)
                   + 3'(progmem_fetch_low | progmem_fetch_high);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      pc_d         = pc_q;
      sp_d         = sp_q;
      data_d       = data_q;
      opcode_d     = opcode_q;
      perr_d       = perr_q;
      w_tape_we    = 1'b0;
      w_tape_waddr = sp_q;
      w_tape_wdata = data_q[7:0];

      if (w_strobe_en) begin
         if (opcode_fetch) begin
            opcode_d = progmem_rdata;
         end

         // Data register writers in fixed priority order.
         if (tape_fetch) begin
            data_d = {8'h00, w_tape_rd};
         end else if (sp_fetch) begin
            data_d = w_sp_ext;
         end else if (alu_en) begin
            data_d = alu_op ? (data_q - 16'd1) : (data_q + 16'd1);
         end else begin
            if (progmem_fetch_low) begin
               data_d[7:0] = progmem_rdata;
            end
            if (progmem_fetch_high) begin
               data_d[15:8] = progmem_rdata;
            end
         end

         if (sp_writeback) begin
            sp_d = data_q[TAPE_AW-1:0];
         end

         // Relative jump wins over increment; two's-complement add covers
         // the signed offset.
         if (pc_writeback) begin
            pc_d = pc_q + data_q;
         end else if (pc_inc) begin
            pc_d = pc_q + 16'd1;
         end

         if (tape_writeback) begin
            w_tape_we = 1'b1;
         end

         if ((w_wr_cnt > 3'd1) || (pc_inc && pc_writeback)) begin
            perr_d = 1'b1;
         end
      end

`ifdef DATAPATH_TAPE_CLEAR_EN
      // The fill owns the write port while busy (strobes are dropped then).
      if (clr_active_q) begin
         w_tape_we    = 1'b1;
         w_tape_waddr = clr_addr_q;
         w_tape_wdata = 8'h00;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q     <= PC_RESET;
         sp_q     <= '0;
         data_q   <= '0;
         opcode_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         sp_q     <= sp_d;
         data_q   <= data_d;
         opcode_q <= opcode_d;
         perr_q   <= perr_d;
      end
   end

   // Tape RAM has no reset; writes are held off while reset_n is low.
   always_ff @(posedge clock) begin
      if (w_tape_we && reset_n) begin
         tape_mem[w_tape_waddr] <= w_tape_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign progmem_addr   = pc_q;
   assign opcode         = opcode_q;
   assign data           = data_q;
   assign busy           = w_busy;
   assign protocol_error = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath
// Description : Self-checking bench for datapath. A behavioural model of the
//               strobe rules runs alongside the DUT and is compared against
//               its outputs every cycle; directed sequences add literal
//               expectations. Tape-clear checks apply when
//               DATAPATH_TAPE_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

   localparam int          AW  = 8;
   localparam int          N   = 1 << AW;
   localparam logic [15:0] PCR = 16'h0000;
`ifdef DATAPATH_TAPE_CLEAR_EN
   localparam int          CLR_CYCLES = N;
`else
   localparam int          CLR_CYCLES = 0;
`endif

   // Strobe bit masks
   localparam logic [10:0] OF = 11'h001, TF = 11'h002, TW = 11'h004,
                           SF = 11'h008, SW = 11'h010, FL = 11'h020,
                           FH = 11'h040, AE = 11'h080, AO = 11'h100,
                           PI = 11'h200, PW = 11'h400;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] strb    = '0;
   logic [7:0]  progmem_rdata = '0;
   logic [15:0] progmem_addr;
   logic [7:0]  opcode;
   logic [15:0] data;
   logic        busy;
   logic        protocol_error;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   datapath #(.TAPE_AW(AW), .PC_RESET(PCR)) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .opcode_fetch       (strb[0]),
      .tape_fetch         (strb[1]),
      .tape_writeback     (strb[2]),
      .sp_fetch           (strb[3]),
      .sp_writeback       (strb[4]),
      .progmem_fetch_low  (strb[5]),
      .progmem_fetch_high (strb[6]),
      .alu_en             (strb[7]),
      .alu_op             (strb[8]),
      .pc_inc             (strb[9]),
      .pc_writeback       (strb[10]),
      .progmem_rdata      (progmem_rdata),
      .progmem_addr       (progmem_addr),
      .opcode             (opcode),
      .data               (data),
      .busy               (busy),
      .protocol_error     (protocol_error)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   logic [15:0]   m_pc, m_data;
   logic [AW-1:0] m_sp;
   logic [7:0]    m_op;
   logic          m_err;
   logic [7:0]    m_tape [N];
   int            m_since_rst = CLR_CYCLES;

   function automatic bit m_busy();
      return m_since_rst < CLR_CYCLES;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pc = PCR; m_sp = '0; m_data = '0; m_op = '0; m_err = 1'b0;
         m_since_rst = 0;
      end else if (m_busy()) begin
         m_tape[m_since_rst] = 8'h00;   // fill walks address 0 upward
         m_since_rst++;
      end else begin
         logic [15:0] nd;
         int          writers;
         nd = m_data;
         writers = int'(strb[1]) + int'(strb[3]) + int'(strb[7])
                 + int'(strb[5] | strb[6]);
         if (writers > 1 || (strb[9] && strb[10])) m_err = 1'b1;
         if (strb[1])       nd = {8'h00, m_tape[m_sp]};
         else if (strb[3])  nd = 16'(m_sp);
         else if (strb[7])  nd = strb[8] ? 16'(int'(m_data) - 1) : 16'(int'(m_data) + 1);
         else begin
            if (strb[5]) nd[7:0]  = progmem_rdata;
            if (strb[6]) nd[15:8] = progmem_rdata;
         end
         if (strb[0])  m_op = progmem_rdata;
         if (strb[2])  m_tape[m_sp] = m_data[7:0];
         if (strb[4])  m_sp = m_data[AW-1:0];
         if (strb[10]) m_pc = 16'(int'(m_pc) + int'($signed(m_data)));
         else if (strb[9]) m_pc = 16'(int'(m_pc) + 1);
         m_data = nd;
      end
   end

   // Compare process: outputs checked every cycle on the falling edge.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("pc",     progmem_addr,              m_pc);
         chk("data",   data,                      m_data);
         chk("opcode", {8'h00, opcode},           {8'h00, m_op});
         chk("perr",   {15'h0, protocol_error},   {15'h0, m_err});
         chk("busy",   {15'h0, busy},             {15'h0, m_busy()});
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic step(input logic [10:0] s, input logic [7:0] rd);
      strb = s;
      progmem_rdata = rd;
      @(posedge clock);
      #1;
      strb = '0;
   endtask

   task automatic reset_pulse();
      strb = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < N + 8) begin
         step('0, 8'h00);
         n++;
      end
      chk("idle_timeout", {15'h0, busy}, 16'h0000);
   endtask

   function automatic logic [10:0] rand_strobe(input bit wild);
      logic [10:0] s;
      s = '0;
      if (wild) begin
         for (int i = 0; i < 11; i++) s[i] = ($urandom_range(0, 3) == 0);
      end else begin
         case ($urandom_range(0, 7))
            0: s = TF;
            1: s = SF;
            2: s = AE;
            3: s = FL;
            4: s = FH;
            5: s = FL | FH;
            default: s = '0;
         endcase
         if ($urandom_range(0, 1) == 1) s = s | AO;
         if ($urandom_range(0, 2) == 0) s = s | OF;
         if ($urandom_range(0, 2) == 0) s = s | TW;
         if ($urandom_range(0, 2) == 0) s = s | SW;
         case ($urandom_range(0, 2))
            1: s = s | PI;
            2: s = s | PW;
            default: ;
         endcase
      end
      return s;
   endfunction

`ifdef DATAPATH_TAPE_CLEAR_EN
   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < N + 8) begin
         cnt++;
         step(rand_strobe(1'b1), 8'($urandom));
      end
   endtask
`endif

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int cnt;
      reset_pulse();
      chk_en = 1'b1;
      chk("rst_pc",   progmem_addr,            16'h0000);
      chk("rst_data", data,                    16'h0000);
      chk("rst_op",   {8'h00, opcode},         16'h0000);
      chk("rst_perr", {15'h0, protocol_error}, 16'h0000);
      wait_idle();

      // Give every tape byte a known value: sp=k, data=0, writeback.
      for (int k = 0; k < N; k++) begin
         step(FL | FH, 8'(k));
         step(SW, 8'h00);
         step(FL | FH, 8'h00);
         step(TW, 8'h00);
      end
      step(FL | FH, 8'h00);
      step(SW, 8'h00);

      // Opcode fetch
      step(OF, 8'h07);
      chk("t1_opcode", {8'h00, opcode}, 16'h0007);
      chk("t1_addr",   progmem_addr,    16'h0000);

      // Increment tape[0] three times
      repeat (3) begin
         step(TF, 8'h00);
         step(AE, 8'h00);
         step(TW, 8'h00);
      end
      step(TF, 8'h00);
      chk("t2_data", data, 16'h0003);

      // Decrement wraps; only the low byte reaches the tape
      step(FL | FH, 8'h00);
      step(TW, 8'h00);
      step(TF, 8'h00);
      step(AE | AO, 8'h00);
      chk("t3_wrap", data, 16'hFFFF);
      step(TW, 8'h00);
      step(TF, 8'h00);
      chk("t3_byte", data, 16'h00FF);

      // SP wraps modulo 2**AW
      step(SF, 8'h00);
      step(AE | AO, 8'h00);
      step(SW, 8'h00);
      step(SF, 8'h00);
      chk("t4_sp_ff", data, 16'h00FF);
      step(AE, 8'h00);
      step(SW, 8'h00);
      step(SF, 8'h00);
      chk("t4_sp_0", data, 16'h0000);

      // Relative PC update, then the illegal pc_inc + pc_writeback pair
      step(FL, 8'h10);
      step(FH, 8'h00);
      step(PW, 8'h00);
      chk("t5_pc10", progmem_addr, 16'h0010);
      step(FL, 8'hFC);
      step(FH, 8'hFF);
      step(PW, 8'h00);
      chk("t5_pc0c", progmem_addr, 16'h000C);
      step(FL, 8'h02);
      step(FH, 8'h00);
      chk("t5_perr_pre", {15'h0, protocol_error}, 16'h0000);
      step(PI | PW, 8'h00);
      chk("t5_pc0e", progmem_addr, 16'h000E);
      chk("t5_perr", {15'h0, protocol_error}, 16'h0001);
      repeat (3) step(OF, 8'h11);
      chk("t5_perr_hold", {15'h0, protocol_error}, 16'h0001);
      reset_pulse();
      chk("t5_perr_clr", {15'h0, protocol_error}, 16'h0000);
      chk("t5_pc_rst",   progmem_addr,            16'h0000);
      wait_idle();

`ifdef DATAPATH_TAPE_CLEAR_EN
      // tape[5] = 0x55, then reset must wipe it during a 256-cycle busy
      step(FL | FH, 8'h05);
      step(SW, 8'h00);
      step(FL | FH, 8'h55);
      step(TW, 8'h00);
      step(TF, 8'h00);
      chk("t6_pre", data, 16'h0055);
      reset_pulse();
      count_busy(cnt);
      chk("t6_busy_len", 16'(cnt), 16'(N));
      step(FL | FH, 8'h05);
      step(SW, 8'h00);
      step(TF, 8'h00);
      chk("t6_cleared", data, 16'h0000);
      // Reset part-way through the fill restarts it
      reset_pulse();
      repeat (100) step(rand_strobe(1'b1), 8'($urandom));
      reset_pulse();
      count_busy(cnt);
      chk("t6_restart_len", 16'(cnt), 16'(N));
`endif

      // Randomized segments: even = mostly legal, odd = anything goes
      for (int seg = 0; seg < 6; seg++) begin
         reset_pulse();
         wait_idle();
         repeat (300) step(rand_strobe(seg[0]), 8'($urandom));
      end

      @(negedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
